// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, runs the instruction-memory req/ack
// handshake and loads the IF/ID pipeline register.
module fetch_stage #(
  parameter int unsigned PC_W = 16,
  localparam int unsigned INSTR_W = 16,
  localparam int unsigned OPC_W = 4,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter logic [INSTR_W-1:0] NOP = 16'h0000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               stall,
  input  logic               jump,
  input  logic [PC_W-1:0]    jumpTarget,
  input  logic               pcsrc1,
  input  logic [PC_W-1:0]    brTarget1,
  input  logic               pcsrc2,
  input  logic [PC_W-1:0]    brTarget2,
  input  logic               IF_ID_Flush,
  output logic               imemReq,
  output logic [PC_W-1:0]    imemAddr,
  input  logic [INSTR_W-1:0] imemRdata,
  input  logic               imemAck,
  output logic [INSTR_W-1:0] IF_ID_instr,
  output logic [PC_W-1:0]    IF_ID_pcPlus1,
  output logic               IF_ID_valid,
  output logic [OPC_W-1:0]   OpCode
);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, HOLD} state_e;

  state_e             state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic [PC_W-1:0]    addr_q, addr_d;
  logic               req_q, req_d;
  logic [INSTR_W-1:0] hold_q, hold_d;
  logic [INSTR_W-1:0] ifid_instr_q, ifid_instr_d;
  logic [PC_W-1:0]    ifid_pc1_q, ifid_pc1_d;
  logic               ifid_valid_q, ifid_valid_d;

  logic               redirect;
  logic [PC_W-1:0]    target;
  logic [PC_W-1:0]    addr_inc;
  logic               deliver;
  logic [INSTR_W-1:0] word;

  // An EX-stage branch belongs to an older instruction than an ID redirect.
  assign redirect = pcsrc2 | pcsrc1 | jump;
  assign target   = pcsrc2 ? brTarget2 : (pcsrc1 ? brTarget1 : jumpTarget);
  assign addr_inc = addr_q + PC_W'(1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      pc_q         <= RESET_PC;
      addr_q       <= RESET_PC;
      req_q        <= 1'b0;
      hold_q       <= NOP;
      ifid_instr_q <= NOP;
      ifid_pc1_q   <= '0;
      ifid_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      addr_q       <= addr_d;
      req_q        <= req_d;
      hold_q       <= hold_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_pc1_q   <= ifid_pc1_d;
      ifid_valid_q <= ifid_valid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    addr_d  = addr_q;
    hold_d  = hold_q;
    deliver = 1'b0;
    word    = hold_q;

    case (state_q)
      IDLE: begin
        addr_d  = pc_q;
        state_d = FETCH;
      end
      FETCH: begin
        if (imemAck) begin
          if (redirect) begin
            pc_d   = target;
            addr_d = target;
          end else if (stall) begin
            hold_d  = imemRdata;
            state_d = HOLD;
          end else begin
            deliver = 1'b1;
            word    = imemRdata;
            pc_d    = addr_inc;
            addr_d  = addr_inc;
          end
        end else if (redirect) begin
          pc_d    = target;
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        // The in-flight wrong-path read must complete before re-issuing.
        if (redirect) pc_d = target;
        if (imemAck) begin
          addr_d  = redirect ? target : pc_q;
          state_d = FETCH;
        end
      end
      HOLD: begin
        if (redirect) begin
          pc_d    = target;
          addr_d  = target;
          state_d = FETCH;
        end else if (!stall) begin
          deliver = 1'b1;
          pc_d    = addr_inc;
          addr_d  = addr_inc;
          state_d = FETCH;
        end
      end
      default: state_d = IDLE;
    endcase

    req_d = (state_d == FETCH) || (state_d == DRAIN);

    ifid_instr_d = ifid_instr_q;
    ifid_pc1_d   = ifid_pc1_q;
    ifid_valid_d = ifid_valid_q;
    if (IF_ID_Flush) begin
      ifid_instr_d = NOP;
      ifid_pc1_d   = '0;
      ifid_valid_d = 1'b0;
    end else if (!stall) begin
      if (deliver) begin
        ifid_instr_d = word;
        ifid_pc1_d   = addr_inc;
        ifid_valid_d = 1'b1;
      end else begin
        ifid_instr_d = NOP;
        ifid_pc1_d   = '0;
        ifid_valid_d = 1'b0;
      end
    end
  end

  assign imemReq       = req_q;
  assign imemAddr      = addr_q;
  assign IF_ID_instr   = ifid_instr_q;
  assign IF_ID_pcPlus1 = ifid_pc1_q;
  assign IF_ID_valid   = ifid_valid_q;
  assign OpCode        = ifid_instr_q[INSTR_W-1 -: OPC_W];

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios plus randomized redirects, stalls
// and memory latency, checked every cycle against a transaction-level model.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall, jump, pcsrc1, pcsrc2, IF_ID_Flush;
  logic [15:0] jumpTarget, brTarget1, brTarget2;
  logic        imemReq, imemAck;
  logic [15:0] imemAddr, imemRdata;
  logic [15:0] IF_ID_instr, IF_ID_pcPlus1;
  logic        IF_ID_valid;
  logic [3:0]  OpCode;

  always #5 clk = ~clk;

  fetch_stage #(.PC_W(16), .RESET_PC(16'h0000), .NOP(16'h0000)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .jump(jump),
    .jumpTarget(jumpTarget), .pcsrc1(pcsrc1), .brTarget1(brTarget1),
    .pcsrc2(pcsrc2), .brTarget2(brTarget2), .IF_ID_Flush(IF_ID_Flush),
    .imemReq(imemReq), .imemAddr(imemAddr), .imemRdata(imemRdata),
    .imemAck(imemAck), .IF_ID_instr(IF_ID_instr),
    .IF_ID_pcPlus1(IF_ID_pcPlus1), .IF_ID_valid(IF_ID_valid), .OpCode(OpCode)
  );

  int vectors = 0;
  int errors  = 0;

  // Model: program counter, address of the outstanding read, whether that
  // read is wrong-path, whether a fetched word is parked by a stall.
  logic [15:0] m_pc, m_addr;
  bit          m_started, m_stale, m_held;
  logic [15:0] e_instr, e_pp1;
  bit          e_valid;

  int wait_cnt = 0;
  int lat = 0;
  bit addr_as_data = 1'b1;
  bit rand_ack = 1'b0;
  bit chk_en = 1'b0;

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    logic [15:0] m;
    m = a * 16'h2F1B;
    return addr_as_data ? a : (m ^ 16'hC3A5);
  endfunction

  function automatic bit exp_req();
    return m_started && !m_held;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    bit          redir, got, req_now;
    logic [15:0] tgt, waddr;
    req_now = exp_req();
    got     = 1'b0;
    waddr   = m_addr;
    if (!rst_n) begin
      m_pc = 16'h0000; m_addr = 16'h0000;
      m_started = 1'b0; m_stale = 1'b0; m_held = 1'b0;
      e_instr = 16'h0000; e_pp1 = 16'h0000; e_valid = 1'b0;
      wait_cnt = 0;
    end else begin
      redir = pcsrc1 || pcsrc2 || jump;
      tgt   = pcsrc2 ? brTarget2 : pcsrc1 ? brTarget1 : jumpTarget;
      if (req_now) wait_cnt = imemAck ? 0 : wait_cnt + 1;
      if (!m_started) begin
        m_started = 1'b1;
        m_addr    = m_pc;
      end else if (m_held) begin
        if (redir) begin
          m_pc = tgt; m_addr = tgt; m_held = 1'b0;
        end else if (!stall) begin
          got = 1'b1; m_pc = waddr + 16'd1; m_addr = m_pc; m_held = 1'b0;
        end
      end else if (m_stale) begin
        if (redir) m_pc = tgt;
        if (imemAck) begin
          m_stale = 1'b0; m_addr = m_pc;
        end
      end else begin
        if (imemAck && redir) begin
          m_pc = tgt; m_addr = tgt;
        end else if (imemAck && stall) begin
          m_held = 1'b1;
        end else if (imemAck) begin
          got = 1'b1; m_pc = waddr + 16'd1; m_addr = m_pc;
        end else if (redir) begin
          m_pc = tgt; m_stale = 1'b1;
        end
      end
      if (IF_ID_Flush) begin
        e_instr = 16'h0000; e_pp1 = 16'h0000; e_valid = 1'b0;
      end else if (!stall) begin
        if (got) begin
          e_instr = mem_word(waddr); e_pp1 = waddr + 16'd1; e_valid = 1'b1;
        end else begin
          e_instr = 16'h0000; e_pp1 = 16'h0000; e_valid = 1'b0;
        end
      end
    end
  endtask

  task automatic drive_mem();
    if (!rst_n) begin
      imemAck   = 1'b1;
      imemRdata = 16'($urandom);
    end else if (exp_req()) begin
      imemAck   = (wait_cnt >= lat);
      imemRdata = imemAck ? mem_word(m_addr) : 16'($urandom);
    end else begin
      imemAck   = rand_ack ? 1'($urandom_range(0, 1)) : 1'b0;
      imemRdata = 16'($urandom);
    end
  endtask

  task automatic tick();
    drive_mem();
    @(posedge clk);
    model_step();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_ctl();
    stall = 1'b0; jump = 1'b0; pcsrc1 = 1'b0; pcsrc2 = 1'b0; IF_ID_Flush = 1'b0;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("imemReq", 32'(imemReq), 32'(exp_req()));
      chk("imemAddr", 32'(imemAddr), 32'(m_addr));
      chk("IF_ID_instr", 32'(IF_ID_instr), 32'(e_instr));
      chk("IF_ID_pcPlus1", 32'(IF_ID_pcPlus1), 32'(e_pp1));
      chk("IF_ID_valid", 32'(IF_ID_valid), 32'(e_valid));
      chk("OpCode", 32'(OpCode), 32'(e_instr[15:12]));
    end
  end

  initial begin
    rst_n = 1'b0;
    clear_ctl();
    jumpTarget = 16'h0; brTarget1 = 16'h0; brTarget2 = 16'h0;
    imemAck = 1'b0; imemRdata = 16'h0;
    @(negedge clk);
    tick();
    chk_en = 1'b1;
    tick();
    chk("rst req", 32'(imemReq), 32'h0);
    chk("rst addr", 32'(imemAddr), 32'h0);
    chk("rst instr", 32'(IF_ID_instr), 32'h0);
    chk("rst valid", 32'(IF_ID_valid), 32'h0);

    // Zero-wait, data = address.
    rst_n = 1'b1;
    tick();
    chk("first req", 32'(imemReq), 32'h1);
    chk("first addr", 32'(imemAddr), 32'h0);
    tick();
    chk("seq0 instr", 32'(IF_ID_instr), 32'h0000);
    chk("seq0 valid", 32'(IF_ID_valid), 32'h1);
    tick();
    chk("seq1 instr", 32'(IF_ID_instr), 32'h0001);
    tick();
    chk("seq2 instr", 32'(IF_ID_instr), 32'h0002);
    tick();
    chk("addr before stall", 32'(imemAddr), 32'h0004);

    // Stall for 3 cycles while address 4 is acknowledged.
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("hold req", 32'(imemReq), 32'h0);
      chk("hold frozen instr", 32'(IF_ID_instr), 32'h0003);
    end
    stall = 1'b0;
    tick();
    chk("release instr", 32'(IF_ID_instr), 32'h0004);
    chk("release addr", 32'(imemAddr), 32'h0005);

    // Redirect into a slow memory, then branch while the read is pending.
    jump = 1'b1; jumpTarget = 16'h0010;
    tick();
    jump = 1'b0;
    lat = 2;
    chk("jump addr", 32'(imemAddr), 32'h0010);
    tick();
    pcsrc1 = 1'b1; brTarget1 = 16'h0040;
    tick();
    pcsrc1 = 1'b0;
    chk("drain addr", 32'(imemAddr), 32'h0010);
    chk("drain valid", 32'(IF_ID_valid), 32'h0);
    tick();
    chk("after drain addr", 32'(imemAddr), 32'h0040);
    chk("after drain valid", 32'(IF_ID_valid), 32'h0);
    tick(); tick(); tick();
    chk("target instr", 32'(IF_ID_instr), 32'h0040);
    chk("target pp1", 32'(IF_ID_pcPlus1), 32'h0041);

    // EX branch beats jump; flush wins over stall.
    lat = 0;
    tick();
    pcsrc2 = 1'b1; brTarget2 = 16'h0100;
    jump = 1'b1; jumpTarget = 16'h0200;
    IF_ID_Flush = 1'b1; stall = 1'b1;
    tick();
    clear_ctl();
    chk("flush valid", 32'(IF_ID_valid), 32'h0);
    chk("flush instr", 32'(IF_ID_instr), 32'h0000);
    chk("prio addr", 32'(imemAddr), 32'h0100);

    // PC wrap.
    jump = 1'b1; jumpTarget = 16'hFFFF;
    tick();
    jump = 1'b0;
    chk("wrap addr0", 32'(imemAddr), 32'hFFFF);
    tick();
    chk("wrap pp1", 32'(IF_ID_pcPlus1), 32'h0000);
    chk("wrap addr", 32'(imemAddr), 32'h0000);
    chk("wrap opcode", 32'(OpCode), 32'hF);

    // Reset while draining a wrong-path read.
    lat = 3;
    tick();
    pcsrc1 = 1'b1; brTarget1 = 16'h0030;
    tick();
    pcsrc1 = 1'b0;
    chk("pre-rst drain addr", 32'(imemAddr), 32'h0000);
    rst_n = 1'b0;
    addr_as_data = 1'b0;
    tick();
    chk("mid rst req", 32'(imemReq), 32'h0);
    chk("mid rst pp1", 32'(IF_ID_pcPlus1), 32'h0);
    rst_n = 1'b1;
    lat = 0;
    tick();
    chk("refetch addr", 32'(imemAddr), 32'h0000);
    tick();
    chk("refetch instr", 32'(IF_ID_instr), 32'hC3A5);

    // Randomized traffic.
    rand_ack = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      rst_n  = ($urandom_range(0, 299) != 0);
      stall  = ($urandom_range(0, 3) == 0);
      jump   = ($urandom_range(0, 9) == 0);
      pcsrc1 = ($urandom_range(0, 9) == 0);
      pcsrc2 = ($urandom_range(0, 11) == 0);
      jumpTarget = 16'($urandom);
      brTarget1  = 16'($urandom);
      brTarget2  = 16'($urandom);
      IF_ID_Flush = (jump || pcsrc1 || pcsrc2) && ($urandom_range(0, 1) == 1);
      if ($urandom_range(0, 49) == 0) lat = $urandom_range(0, 3);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage and IF/ID pipeline register for the 16-bit, 4-bit-opcode RISC pipeline. It owns the PC, issues requests to instruction memory over a req/ack handshake, and delivers one instruction per cycle into IF/ID. Its `OpCode` output feeds the decode-stage control unit. It applies that unit's redirect and flush outputs (`pcsrc1`, `pcsrc2`, `jump`, `IF_ID_Flush`) together with the hazard unit's `stall`.

## Interface
Parameters:
- PC_W, 16, PC and instruction-address width; word addressed.
- RESET_PC, 0, first fetch address after reset.
- NOP, 16'h0000, bubble instruction. Opcode 0000 decodes to all-zero controls.

Ports:
- clk  in  1  single clock; all state updates on the rising edge
- rst_n  in  1  synchronous, active-low reset
- stall  in  1  load-use hazard; freeze IF/ID and the PC
- jump  in  1  ID-stage jump; target `jumpTarget`
- jumpTarget  in  PC_W  jump destination
- pcsrc1  in  1  ID-resolved branch taken; target `brTarget1`
- brTarget1  in  PC_W  ID branch destination
- pcsrc2  in  1  EX-resolved branch taken; target `brTarget2`
- brTarget2  in  PC_W  EX branch destination
- IF_ID_Flush  in  1  load a bubble into IF/ID this edge
- imemReq  out  1  instruction-memory request
- imemAddr  out  PC_W  request address; stable while `imemReq` is high and `imemAck` is low
- imemRdata  in  16  instruction word; valid when `imemAck` is high
- imemAck  in  1  read complete; sampled only while `imemReq` is high
- IF_ID_instr  out  16  registered instruction
- IF_ID_pcPlus1  out  PC_W  address of the registered instruction + 1
- IF_ID_valid  out  1  1 = real instruction, 0 = bubble
- OpCode  out  4  equals `IF_ID_instr[15:12]`, combinational

## Operation
Redirect:
- `redirect` = `pcsrc2 | pcsrc1 | jump`.
- Target priority: `pcsrc2` > `pcsrc1` > `jump`. An EX branch belongs to the older instruction and overrides.

State machine states: IDLE, FETCH, DRAIN, HOLD.
- Reset values: state IDLE, `pc` = RESET_PC, `imemReq` = 0, `imemAddr` = RESET_PC, `IF_ID_instr` = NOP, `IF_ID_pcPlus1` = 0, `IF_ID_valid` = 0.
- IDLE: always goes to FETCH next cycle. `imemAddr` <= `pc`.
- FETCH: `imemReq` = 1.
  - ack, no redirect, no stall: IF/ID <= {`imemRdata`, `imemAddr`+1, valid 1}. `pc` and `imemAddr` <= `imemAddr`+1. Stay in FETCH (back-to-back requests).
  - ack, no redirect, stall: capture the word in the one-entry hold buffer, go to HOLD. IF/ID is unchanged.
  - ack with redirect: discard the word. `pc` and `imemAddr` <= target. Stay in FETCH.
  - no ack with redirect: `pc` <= target, go to DRAIN. `imemAddr` holds its value.
  - no ack, no redirect: wait.
- DRAIN: `imemReq` = 1 at the stale address.
  - A further redirect overwrites `pc` (latest wins).
  - On ack: discard the data. `imemAddr` <= `pc` (the redirect target if one arrives this cycle), go to FETCH.
- HOLD: `imemReq` = 0.
  - stall low, no redirect: IF/ID <= the held word, `pc` and `imemAddr` <= held address + 1, go to FETCH.
  - redirect: drop the held word, `pc` and `imemAddr` <= target, go to FETCH.

IF/ID register rules:
- `IF_ID_Flush` has highest priority. IF/ID <= {NOP, 0, valid 0}, regardless of stall or of a word delivered that edge; that word is discarded.
- Otherwise `stall` freezes IF/ID.
- Otherwise, if no word is delivered, IF/ID <= bubble.

Arithmetic:
- PC increment is modulo 2^PC_W. 0xFFFF + 1 wraps to 0x0000.
- No other exceptions exist.

## Timing
- Zero-wait memory (`imemAck` tied high): throughput is 1 instruction per clock. A fetch issued at edge N is in IF/ID after edge N+1.
- Redirect asserted in cycle N: the target address is on `imemAddr` in cycle N+1 (N+2 if in DRAIN awaiting ack). The wrong-path word is never written to IF/ID.
- The first `imemReq` is asserted in the second cycle after `rst_n` rises.
- `rst_n` low at any edge returns every register to its reset value, including mid-DRAIN or HOLD. An ack arriving during reset is ignored.
- `stall` together with redirect: the redirect takes effect. `stall` never delays a PC redirect.

## Test plan
- Reset, zero-wait memory returning addr-as-data: IF_ID_instr sequence 0x0000, 0x0001, 0x0002 on consecutive cycles, with `IF_ID_valid` 1 from the third cycle.
- `stall` high 3 cycles while ack arrives at address 0x0004: IF/ID frozen, `imemReq` low in HOLD. After release, IF_ID_instr = word@0x0004 and next `imemAddr` = 0x0005.
- Memory with 3-cycle ack, `pcsrc1` (target 0x0040) pulsed one cycle after request to 0x0010: `imemAddr` stays 0x0010 until ack. Data is discarded, next request is to 0x0040, and 0x0010's word never reaches IF/ID.
- `pcsrc2` target 0x0100 and `jump` target 0x0200 asserted together with `IF_ID_Flush`: IF/ID = NOP valid 0, next `imemAddr` = 0x0100.
- `pc` = 0xFFFF, zero-wait fetch: `IF_ID_pcPlus1` = 0x0000, next `imemAddr` = 0x0000.
- `rst_n` low during DRAIN: next cycle all outputs are at reset values and a fresh fetch of RESET_PC follows.
